// File: rtl/sparce_pkg.sv
// Shared types and helpers for the SparCE sparsity register file.
package sparce_pkg;

  typedef enum logic [1:0] {
    SPRF_IDLE  = 2'd0,
    SPRF_CLEAR = 2'd1,
    SPRF_DONE  = 2'd2
  } sprf_clr_state_t;

  localparam int SPRF_NUM_REGS = 32;

  function automatic int sprf_aw(input int num_regs);
    return $clog2(num_regs);
  endfunction

  localparam int SPRF_AW = sprf_aw(SPRF_NUM_REGS);

endpackage

// File: rtl/sparce_sprf_wb_arb.sv
// Writeback resolution for one register index: the highest-numbered effective
// port targeting idx_i wins; writes to index 0 never count.
module sparce_sprf_wb_arb
  import sparce_pkg::*;
#(
  parameter int NUM_WB = 1,
  parameter int AW     = 5
) (
  input  logic [NUM_WB-1:0]         wb_en_i,
  input  logic [NUM_WB-1:0][AW-1:0] wb_rd_i,
  input  logic [NUM_WB-1:0]         wb_sparse_i,
  input  logic [AW-1:0]             idx_i,
  output logic                      hit_o,
  output logic                      val_o
);

  always_comb begin
    hit_o = 1'b0;
    val_o = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_en_i[k] && (wb_rd_i[k] != '0) && (wb_rd_i[k] == idx_i)) begin
        hit_o = 1'b1;
        val_o = wb_sparse_i[k];
      end
    end
  end

endmodule

// File: rtl/sparce_sprf_mp.sv
// Multi-ported sparsity register file with bypassed lookups and a background
// clear sequencer that never stalls writeback.
module sparce_sprf_mp
  import sparce_pkg::*;
#(
  parameter int  NUM_REGS      = 32,
  parameter int  NUM_RD        = 2,
  parameter int  NUM_WB        = 1,
  parameter int  CLR_PER_CYCLE = 4,
  localparam int AW            = sprf_aw(NUM_REGS)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_WB-1:0]         wb_en,
  input  logic [NUM_WB-1:0][AW-1:0] wb_rd,
  input  logic [NUM_WB-1:0]         wb_sparse,
  input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]         rd_sparse,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done
);

  localparam logic [AW:0] STEP = (AW+1)'(CLR_PER_CYCLE);
  localparam logic [AW:0] NREG = (AW+1)'(NUM_REGS);
  localparam logic [AW:0] PTR0 = (AW+1)'(1);

  sprf_clr_state_t     state_q;
  logic [AW:0]         ptr_q;
  logic                busy_q, done_q;
  logic [NUM_REGS-1:0] sp_q, sp_d;
  logic [NUM_REGS-1:0] touched_q, touched_d;
  logic                clearing;

  // A restart request pre-empts the clear step of its own cycle.
  assign clearing  = (state_q == SPRF_CLEAR) && !clr_req;
  assign sp_d[0]      = 1'b0;
  assign touched_d[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    localparam logic [AW:0] IDX = (AW+1)'(i);
    logic w_hit, w_val, in_grp;

    sparce_sprf_wb_arb #(.NUM_WB(NUM_WB), .AW(AW)) u_wb_arb (
      .wb_en_i    (wb_en),
      .wb_rd_i    (wb_rd),
      .wb_sparse_i(wb_sparse),
      .idx_i      (AW'(i)),
      .hit_o      (w_hit),
      .val_o      (w_val)
    );

    assign in_grp       = clearing && (ptr_q <= IDX) && (IDX < ptr_q + STEP) && !touched_q[i];
    assign sp_d[i]      = w_hit ? w_val : (in_grp ? 1'b0 : sp_q[i]);
    assign touched_d[i] = clr_req ? 1'b0 : ((clearing && w_hit) ? 1'b1 : touched_q[i]);
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_read
    logic r_hit, r_val, pend;

    sparce_sprf_wb_arb #(.NUM_WB(NUM_WB), .AW(AW)) u_rd_arb (
      .wb_en_i    (wb_en),
      .wb_rd_i    (wb_rd),
      .wb_sparse_i(wb_sparse),
      .idx_i      (rd_addr[p]),
      .hit_o      (r_hit),
      .val_o      (r_val)
    );

    // Entries the sequencer has not reached yet already report non-sparse.
    assign pend = (state_q == SPRF_CLEAR) && ({1'b0, rd_addr[p]} >= ptr_q) &&
                  !touched_q[rd_addr[p]];
    assign rd_sparse[p] = (rd_addr[p] == '0) ? 1'b1 :
                          r_hit              ? r_val :
                          pend               ? 1'b0 : sp_q[rd_addr[p]];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= SPRF_IDLE;
      ptr_q     <= PTR0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sp_q      <= '0;
      touched_q <= '0;
    end else begin
      sp_q      <= sp_d;
      touched_q <= touched_d;
      case (state_q)
        SPRF_CLEAR: begin
          if (clr_req) begin
            ptr_q <= PTR0;
          end else if (ptr_q + STEP >= NREG) begin
            state_q <= SPRF_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + STEP;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (clr_req) begin
            state_q <= SPRF_CLEAR;
            ptr_q   <= PTR0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= SPRF_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_sparce_sprf_mp.sv
// Bench for sparce_sprf_mp (2 read ports, 2 writeback ports): directed checks
// plus a randomized run against a pending-set model of the clear sequencer.
module tb_sparce_sprf_mp;

  localparam int NR     = 32;
  localparam int AW     = 5;
  localparam int NSTEPS = 8;

  logic                clk, n_rst;
  logic [1:0]          wb_en, wb_sparse;
  logic [1:0][AW-1:0]  wb_rd;
  logic [1:0][AW-1:0]  rd_addr;
  logic [1:0]          rd_sparse;
  logic                clr_req, clr_busy, clr_done;

  int n_cmp  = 0;
  int n_fail = 0;

  sparce_sprf_mp #(.NUM_REGS(NR), .NUM_RD(2), .NUM_WB(2), .CLR_PER_CYCLE(4)) dut (
    .CLK      (clk),
    .nRST     (n_rst),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_sparse(wb_sparse),
    .rd_addr  (rd_addr),
    .rd_sparse(rd_sparse),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stored bits, set of indices the current clear has still to reach,
  // and the phase of the clear (0 idle, 1 clearing step m_n, 2 done).
  bit m_sp[NR];
  bit m_pend[NR];
  int m_phase, m_n;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NR; i++) begin
        m_sp[i]   <= 1'b0;
        m_pend[i] <= 1'b0;
      end
      m_phase <= 0;
      m_n     <= 0;
    end else begin : upd
      bit sp[NR];
      bit pend[NR];
      bit wr[NR];
      int ph, n;
      sp = m_sp; pend = m_pend; ph = m_phase; n = m_n;
      for (int i = 0; i < NR; i++) wr[i] = 1'b0;
      for (int k = 0; k < 2; k++)
        if (wb_en[k] && wb_rd[k] != 0) begin
          sp[wb_rd[k]] = wb_sparse[k];
          wr[wb_rd[k]] = 1'b1;
        end
      if (clr_req) begin
        ph = 1; n = 0;
        for (int i = 1; i < NR; i++) pend[i] = 1'b1;
      end else if (ph == 1) begin
        for (int i = 1; i < NR; i++) if (wr[i]) pend[i] = 1'b0;
        for (int i = 1 + 4*n; i <= 4*n + 4 && i < NR; i++)
          if (pend[i]) begin sp[i] = 1'b0; pend[i] = 1'b0; end
        n++;
        if (n == NSTEPS) ph = 2;
      end else begin
        ph = 0;
      end
      m_sp <= sp; m_pend <= pend; m_phase <= ph; m_n <= n;
    end
  end

  function automatic bit exp_rd(input logic [AW-1:0] a);
    bit hit, v;
    hit = 1'b0; v = 1'b0;
    for (int k = 0; k < 2; k++)
      if (wb_en[k] && wb_rd[k] != 0 && wb_rd[k] == a) begin hit = 1'b1; v = wb_sparse[k]; end
    if (a == 0) return 1'b1;
    if (hit) return v;
    if (m_phase == 1 && m_pend[a]) return 1'b0;
    return m_sp[a];
  endfunction

  // Scoreboard: every cycle out of reset, outputs vs. the model.
  always @(negedge clk) begin
    if (n_rst) begin
      check("rd0", 32'(rd_sparse[0]), 32'(exp_rd(rd_addr[0])));
      check("rd1", 32'(rd_sparse[1]), 32'(exp_rd(rd_addr[1])));
      check("busy", 32'(clr_busy), 32'(m_phase == 1));
      check("done", 32'(clr_done), 32'(m_phase == 2));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = '0; wb_rd = '0; wb_sparse = '0; clr_req = 1'b0;
  endtask

  task automatic set_all_sparse();
    for (int i = 1; i < NR; i += 2) begin
      wb_en = 2'b11; wb_sparse = 2'b11;
      wb_rd[0] = AW'(i); wb_rd[1] = AW'(i + 1);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at;
    n_rst = 1'b0; rd_addr = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // reset contents
    for (int a = 0; a < NR; a++) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(NR - 1 - a);
      @(negedge clk);
      check("rst_rd0", 32'(rd_sparse[0]), 32'(a == 0));
      check("rst_rd1", 32'(rd_sparse[1]), 32'(a == NR - 1));
      check("rst_busy", 32'(clr_busy), 32'd0);
      step();
    end

    // bypass, then storage, then ignored write to index 0
    wb_en = 2'b01; wb_rd[0] = 5'd5; wb_sparse = 2'b01; rd_addr[0] = 5'd5;
    @(negedge clk); check("byp5", 32'(rd_sparse[0]), 32'd1);
    step(); idle_inputs();
    @(negedge clk); check("store5", 32'(rd_sparse[0]), 32'd1);
    wb_en = 2'b01; wb_rd[0] = 5'd0; wb_sparse = 2'b00; rd_addr[0] = 5'd0;
    @(negedge clk); check("r0_byp", 32'(rd_sparse[0]), 32'd1);
    step(); idle_inputs();
    @(negedge clk); check("r0_after", 32'(rd_sparse[0]), 32'd1);

    // two ports on index 9: port 1 wins
    wb_en = 2'b01; wb_rd[0] = 5'd9; wb_sparse = 2'b01;
    step();
    wb_en = 2'b11; wb_rd[0] = 5'd9; wb_rd[1] = 5'd9; wb_sparse = 2'b01; rd_addr[1] = 5'd9;
    @(negedge clk); check("wb9_same", 32'(rd_sparse[1]), 32'd0);
    step(); idle_inputs();
    @(negedge clk); check("wb9_next", 32'(rd_sparse[1]), 32'd0);

    // full clear with a protected write to 30 in the second clear cycle
    set_all_sparse();
    clr_req = 1'b1; rd_addr[0] = 5'd20; rd_addr[1] = 5'd30;
    @(negedge clk); check("pre_clr20", 32'(rd_sparse[0]), 32'd1);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      clr_req = 1'b0;
      if (c == 2) begin wb_en = 2'b01; wb_rd[0] = 5'd30; wb_sparse = 2'b01; end
      else idle_inputs();
      @(negedge clk);
      if (c == 1) check("clr_20_zero", 32'(rd_sparse[0]), 32'd0);
      check("clr_30", 32'(rd_sparse[1]), 32'(c >= 2));
      busy_cnt += int'(clr_busy);
      if (clr_done) begin done_cnt++; done_at = c; end
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd8);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);
    check("clr_done_at", 32'(done_at), 32'd9);
    for (int a = 1; a < NR; a++) begin
      rd_addr[0] = AW'(a);
      @(negedge clk); check("post_clr", 32'(rd_sparse[0]), 32'(a == 30));
      step();
    end

    // restart in clear cycle 4
    set_all_sparse();
    clr_req = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 18; c++) begin
      step();
      clr_req = (c == 4);
      @(negedge clk);
      busy_cnt += int'(clr_busy);
      if (clr_done) begin done_cnt++; done_at = c; end
    end
    check("rst_busy_cycles", 32'(busy_cnt), 32'd12);
    check("rst_done_cnt", 32'(done_cnt), 32'd1);
    check("rst_done_at", 32'(done_at), 32'd13);

    // asynchronous reset mid-clear
    set_all_sparse();
    clr_req = 1'b1; rd_addr[0] = 5'd3;
    step(); clr_req = 1'b0;
    repeat (3) step();
    #2 n_rst = 1'b0;
    #1;
    check("arst_busy", 32'(clr_busy), 32'd0);
    check("arst_done", 32'(clr_done), 32'd0);
    check("arst_rd3", 32'(rd_sparse[0]), 32'd0);
    @(posedge clk); #1 n_rst = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      done_cnt += int'(clr_done);
      busy_cnt += int'(clr_busy);
      step();
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);
    check("arst_no_busy", 32'(busy_cnt), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      wb_en     = 2'($urandom_range(0, 3));
      wb_sparse = 2'($urandom_range(0, 3));
      wb_rd[0]  = AW'($urandom_range(0, NR - 1));
      wb_rd[1]  = ($urandom_range(0, 3) == 0) ? wb_rd[0] : AW'($urandom_range(0, NR - 1));
      rd_addr[0] = ($urandom_range(0, 2) == 0) ? wb_rd[0] : AW'($urandom_range(0, NR - 1));
      rd_addr[1] = ($urandom_range(0, 2) == 0) ? wb_rd[1] : AW'($urandom_range(0, NR - 1));
      clr_req   = ($urandom_range(0, 24) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sparce_sprf_mp.md
Name: sparce_sprf_mp

Overview:
- Parametrised, multi-ported sparsity register file (SpRF) for the SparCE pipeline.
- Holds one "value is zero" bit per architectural register.
- Serves NUM_RD combinational sparsity lookups for the SASA stage and accepts NUM_WB writeback updates per cycle.
- Adds a multi-cycle clear sequencer, used on context switch and fence, that invalidates sparsity state without stalling writeback.

Parameters:
- NUM_REGS, 32, number of architectural registers; entry 0 is hardwired sparse; power of two, >= 4.
- NUM_RD, 2, number of read (lookup) ports.
- NUM_WB, 1, number of writeback ports.
- CLR_PER_CYCLE, 4, entries cleared per cycle by the sequencer; 1..NUM_REGS-1.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- wb_en  input  NUM_WB  per-port writeback valid.
- wb_rd  input  NUM_WB x AW  writeback destination index; AW = $clog2(NUM_REGS).
- wb_sparse  input  NUM_WB  1 = written value is zero.
- rd_addr  input  NUM_RD x AW  lookup index.
- rd_sparse  output  NUM_RD  sparsity of the looked-up register.
- clr_req  input  1  single-cycle pulse that starts or restarts a clear.
- clr_busy  output  1  sequencer active.
- clr_done  output  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (asynchronous): all stored bits 1..NUM_REGS-1 = 0; touched bits = 0; FSM = IDLE; clr_ptr = 1. Outputs after reset: clr_busy = 0, clr_done = 0.
- Storage: sp[i] for i >= 1; sp[0] reads as 1 at all times.
- Write resolution:
  - A port is effective when wb_en[k] = 1 and wb_rd[k] != 0.
  - If several effective ports target the same index, the highest k wins.
  - Writes to index 0 are ignored.
  - Write latency: stored value updates on the next rising edge.
- Read (combinational, same cycle), in priority order:
  1. rd_addr == 0 -> 1.
  2. Index matches an effective write this cycle -> winning wb_sparse (bypass).
  3. FSM = CLEAR, index >= clr_ptr and touched[index] = 0 -> 0 (pending clear; reported non-sparse).
  4. Otherwise -> sp[index].
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - clr_req -> CLEAR.
  - On that edge: clr_ptr <= 1; all touched <= 0.
- CLEAR:
  - Each cycle, indices clr_ptr .. min(clr_ptr+CLR_PER_CYCLE-1, NUM_REGS-1) with touched = 0 are written to 0.
  - clr_ptr advances by CLR_PER_CYCLE.
  - When the last group has been cleared, the next state is DONE.
  - clr_busy = 1 throughout.
- Writes during CLEAR:
  - Applied normally.
  - Set touched[rd]; touched entries are skipped by later clear steps.
  - A write and a clear step on the same index in the same cycle: the write wins and sets touched.
- DONE:
  - clr_done = 1 and clr_busy = 0 for one cycle, then IDLE.
  - clr_req in DONE behaves as in IDLE.
- clr_req during CLEAR restarts the clear: clr_ptr <= 1 and touched <= 0 on that edge, with no clr_done for the aborted pass.
- Clear duration: ceil((NUM_REGS-1)/CLR_PER_CYCLE) cycles in CLEAR. The default configuration takes 8 cycles; clr_done is asserted in the 9th cycle after the clr_req edge.
- Reset during CLEAR: immediate return to IDLE with all entries 0; no clr_done.
- clr_ptr width: AW+1 bits so the final step does not wrap.

Decomposition:
- sparce_pkg additions:
  - sprf_clr_state_t enum (IDLE, CLEAR, DONE).
  - Constant SPRF_AW function of NUM_REGS (via $clog2).
- One sub-module: sparce_sprf_wb_arb.
  - Combinational; given an index, returns hit and value for highest-index-wins write resolution.
  - One instance per read port plus one per storage entry, or as a shared function.
- Sequencer and storage stay in the top module.

Test Plan:
- Reset, then read all indices on both ports -> index 0 returns 1, indices 1..31 return 0; clr_busy = 0.
- wb port0 writes rd = 5 with sparse = 1 while rd_addr[0] = 5 in the same cycle -> rd_sparse[0] = 1 via bypass; after the edge, still 1 from storage; rd = 0 write with sparse = 0 leaves index 0 reading 1.
- NUM_WB = 2: both ports write rd = 9, port0 sparse = 1 and port1 sparse = 0 -> read of 9 returns 0 in the same and the next cycle.
- Set all entries sparse, pulse clr_req -> clr_busy high for 8 cycles.
  - Index 20 reads 0 immediately.
  - After clr_done (one cycle, 9th cycle after request), all indices 1..31 read 0.
- During a clear, write rd = 30 with sparse = 1 in the second CLEAR cycle (clr_ptr = 5) -> index 30 reads 1 from that cycle on and after clr_done.
- clr_req again at CLEAR cycle 4 -> ptr restarts, busy lasts 8 more cycles, exactly one clr_done; an nRST pulse mid-clear -> busy = 0 and no clr_done.
